// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the multiplier issue sequencer
// Contents:
//   state_t      sequencer state encodings (IDLE..RESP)
//   DEF_WIDTH    default operand/product width
//   DEF_TIMEOUT  default watchdog limit in WAIT cycles
//   DEF_WD_W     watchdog counter width for the default limit
//   wd_width()   watchdog counter width for an arbitrary limit
package mul_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_WD_W    = $clog2(DEF_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    function automatic int wd_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/mul_watchdog.sv
// rtl/mul_watchdog.sv - loadable up-counter with clear, enable and terminal-count flag
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        force count to zero (highest priority)
//   load         load count from load_value
//   load_value   value loaded when load is high
//   enable       increment count
//   terminal     count equals TIMEOUT-1
module mul_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int W       = $clog2(TIMEOUT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         terminal
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != LAST) begin
            // Saturate at the terminal value so the flag cannot wrap away.
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mul_issue_seq.sv
// rtl/mul_issue_seq.sv - serialises operand pairs onto a repeated-addition multiplier
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready/req_a/b   operand pair request channel
//   rsp_valid/rsp_ready           result response channel
//   rsp_product, rsp_timeout      product (0 on timeout or zero operand), watchdog abort flag
//   mul_start, mul_datain         multiplier controller start and shared operand bus
//   mul_done, mul_out             multiplier completion and product
module mul_issue_seq
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_product,
    output logic             rsp_timeout,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_datain,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_out
);

    localparam int WD_W = wd_width(TIMEOUT);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
    logic [WIDTH-1:0] rsp_product_nxt, mul_datain_nxt;
    logic             rsp_timeout_nxt, mul_start_nxt;
    logic             wd_clear, wd_enable, wd_terminal;

    mul_watchdog #(
        .TIMEOUT (TIMEOUT),
        .W       (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (wd_clear),
        .load       (1'b0),
        .load_value ({WD_W{1'b0}}),
        .enable     (wd_enable),
        .terminal   (wd_terminal)
    );

    always_comb begin
        state_nxt       = state;
        a_nxt           = a_q;
        b_nxt           = b_q;
        rsp_product_nxt = rsp_product;
        rsp_timeout_nxt = rsp_timeout;
        wd_clear        = 1'b0;
        wd_enable       = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    a_nxt = req_a;
                    b_nxt = req_b;
                    if (req_a == '0 || req_b == '0) begin
                        // Trivial product: answer directly, leave the multiplier idle.
                        state_nxt       = RESP;
                        rsp_product_nxt = '0;
                        rsp_timeout_nxt = 1'b0;
                    end else begin
                        state_nxt = START;
                    end
                end
            end
            START:  state_nxt = LOAD_A;
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: begin
                state_nxt = WAIT;
                wd_clear  = 1'b1;
            end
            WAIT: begin
                wd_enable = 1'b1;
                // done is checked first so it wins over a coincident timeout.
                if (mul_done) begin
                    state_nxt       = RESP;
                    rsp_product_nxt = mul_out;
                    rsp_timeout_nxt = 1'b0;
                end else if (wd_terminal) begin
                    state_nxt       = RESP;
                    rsp_product_nxt = '0;
                    rsp_timeout_nxt = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside it and change on the same edge as the state.
        mul_start_nxt  = (state_nxt == START) || (state_nxt == LOAD_A) ||
                         (state_nxt == LOAD_B) || (state_nxt == WAIT);
        mul_datain_nxt = '0;
        if (state_nxt == LOAD_A) begin
            mul_datain_nxt = a_nxt;
        end else if (state_nxt == LOAD_B || state_nxt == WAIT) begin
            mul_datain_nxt = b_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_timeout <= 1'b0;
            mul_start   <= 1'b0;
            mul_datain  <= '0;
        end else begin
            state       <= state_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            req_ready   <= (state_nxt == IDLE);
            rsp_valid   <= (state_nxt == RESP);
            rsp_product <= rsp_product_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            mul_start   <= mul_start_nxt;
            mul_datain  <= mul_datain_nxt;
        end
    end

endmodule
